// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter with fixed request-to-grant latency and a post-grant hold.
// Define RRA_SVA_EN to compile the embedded protocol assertions.
module rr_handshake_arbiter #(
  parameter int N        = 4,
  parameter int GNT_DLY  = 2,
  parameter int BUSY_CYC = 1,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic [N-1:0]   pend
);

  localparam int WCW = (GNT_DLY > 1) ? $clog2(GNT_DLY) : 1;
  localparam int BCW = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;
  localparam logic [WCW-1:0] WCNT_INIT = WCW'(GNT_DLY - 1);
  localparam logic [BCW-1:0] BCNT_INIT = BCW'((BUSY_CYC > 0) ? BUSY_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    BUSY  = 2'd3
  } state_t;

  state_t           state;
  logic [IDW-1:0]   last;
  logic [WCW-1:0]   wcnt;
  logic [BCW-1:0]   bcnt;
  logic [N-1:0]     cand;
  logic [N-1:0]     acc_mask;
  logic [N-1:0]     win_hot;
  logic [N-1:0]     gnt_hot;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   scan_idx;
  logic             accept;

  // Handshake: every high req sample is one request; the winner is accepted
  // on an IDLE edge and sees a single-cycle gnt pulse GNT_DLY+1 edges later.
  assign cand     = pend | req;
  assign accept   = (state == IDLE) && (cand != '0);
  assign win_hot  = {{(N-1){1'b0}}, 1'b1} << win_id;
  assign gnt_hot  = {{(N-1){1'b0}}, 1'b1} << gnt_id;
  assign acc_mask = accept ? win_hot : '0;
  assign busy     = (state != IDLE);

  // Scan from the far end so the position closest to last+1 is written last.
  always_comb begin
    win_id   = '0;
    scan_idx = '0;
    for (int i = N; i >= 1; i--) begin
      scan_idx = IDW'((int'(last) + i) % N);
      if (cand[scan_idx]) win_id = scan_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= (pend | req) & ~acc_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      last   <= IDW'(N - 1);
      wcnt   <= '0;
      bcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= WAIT;
            gnt_id <= win_id;
            last   <= win_id;
            wcnt   <= WCNT_INIT;
          end
        end
        WAIT: begin
          if (wcnt == '0) begin
            state <= GRANT;
            gnt   <= gnt_hot;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        GRANT: begin
          gnt <= '0;
          if (BUSY_CYC == 0) begin
            state <= IDLE;
          end else begin
            state <= BUSY;
            bcnt  <= BCNT_INIT;
          end
        end
        BUSY: begin
          if (bcnt == '0) state <= IDLE;
          else            bcnt  <= bcnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RRA_SVA_EN
  // acc_pipe[GNT_DLY] lines up with the cycle in which gnt must be high.
  logic [GNT_DLY:0] acc_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_pipe <= '0;
    else     acc_pipe <= {acc_pipe[GNT_DLY-1:0], accept};
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("gnt not onehot0: %b", gnt);

  a_gnt_latency: assert property (@(posedge clk) disable iff (rst)
    gnt == (acc_pipe[GNT_DLY] ? gnt_hot : {N{1'b0}}))
    else $error("gnt timing wrong: gnt=%b id=%0d", gnt, gnt_id);

  a_gnt_busy: assert property (@(posedge clk) disable iff (rst) (gnt != '0) |-> busy)
    else $error("gnt without busy");

  a_no_accept_busy: assert property (@(posedge clk) disable iff (rst) busy |-> !accept)
    else $error("accept while busy");
`endif

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Directed and randomized scenarios for rr_handshake_arbiter (N=4, GNT_DLY=2, BUSY_CYC=1).
module tb_rr_handshake_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic [N-1:0] pend;

  int checks = 0;
  int errors = 0;
  int edge_no = -1;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rr_handshake_arbiter #(.N(N), .GNT_DLY(2), .BUSY_CYC(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .pend   (pend)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  // Expected entry: {sample edge, gnt value}.
  task automatic push_gnt(input int e, input logic [N-1:0] g);
    exp_q.push_back({16'(e), 12'h0, g});
  endtask

  // Advance one edge and observe outputs at the following negedge.
  // A gnt seen here is the value sampled at edge edge_no+1.
  task automatic tick;
    logic [31:0] e;
    @(posedge clk);
    edge_no++;
    @(negedge clk);
    if (gnt !== '0) begin
      if (exp_q.size() == 0) begin
        check_eq("gnt_unexpected", {16'(edge_no + 1), 12'h0, gnt}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check_eq("gnt", {16'(edge_no + 1), 12'h0, gnt}, e);
      end
    end
  endtask

  task automatic run_to(input int e);
    while (edge_no < e) tick();
  endtask

  task automatic drain_check(input string tag);
    check_eq(tag, exp_q.size(), 32'd0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    #1;
    check_eq("rst_gnt", gnt, 32'h0);
    check_eq("rst_id", gnt_id, 32'h0);
    check_eq("rst_busy", busy, 32'h0);
    check_eq("rst_pend", pend, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    edge_no = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;

    // 1: single request from requester 2
    do_reset();
    req = 4'b0100;
    push_gnt(3, 4'b0100);
    tick();
    req = '0;
    check_eq("t1_id", gnt_id, 32'd2);
    for (int i = 0; i < 5; i++) begin
      check_eq("t1_busy", busy, (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    run_to(8);
    check_eq("t1_id_hold", gnt_id, 32'd2);
    drain_check("t1_drain");

    // 2: all four request once, served in rotation
    do_reset();
    req = 4'b1111;
    push_gnt(3, 4'b0001);
    push_gnt(8, 4'b0010);
    push_gnt(13, 4'b0100);
    push_gnt(18, 4'b1000);
    tick();
    req = '0;
    check_eq("t2_pend0", pend, 32'hE);
    run_to(5);
    check_eq("t2_pend5", pend, 32'hC);
    run_to(14);
    check_eq("t2_pend14", pend, 32'h8);
    tick();
    check_eq("t2_pend15", pend, 32'h0);
    run_to(22);
    drain_check("t2_drain");

    // 3: requester 0 held high, requester 1 pulsed at edges 0 and 7
    do_reset();
    req = 4'b0011;
    push_gnt(3, 4'b0001);
    push_gnt(8, 4'b0010);
    push_gnt(13, 4'b0001);
    push_gnt(18, 4'b0010);
    push_gnt(23, 4'b0001);
    tick();
    req = 4'b0001;
    run_to(6);
    req = 4'b0011;
    tick();
    req = 4'b0001;
    run_to(20);
    req = '0;
    run_to(28);
    check_eq("t3_pend_end", pend, 32'h0);
    drain_check("t3_drain");

    // 4: reset during WAIT drops the grant and pending requests
    do_reset();
    req = 4'b1001;
    tick();
    req = '0;
    check_eq("t4_pend", pend, 32'h8);
    tick();
    rst = 1'b1;
    #1;
    check_eq("t4_rst_gnt", gnt, 32'h0);
    check_eq("t4_rst_pend", pend, 32'h0);
    check_eq("t4_rst_busy", busy, 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    edge_no = -1;
    req = 4'b1001;
    push_gnt(3, 4'b0001);
    push_gnt(8, 4'b1000);
    tick();
    req = '0;
    check_eq("t4_id", gnt_id, 32'd0);
    run_to(11);
    drain_check("t4_drain");

    // 5: request arriving during WAIT only pends
    do_reset();
    req = 4'b1000;
    push_gnt(3, 4'b1000);
    push_gnt(8, 4'b0010);
    tick();
    req = '0;
    tick();
    req = 4'b0010;
    tick();
    req = '0;
    check_eq("t5_pend2", pend, 32'h2);
    check_eq("t5_id_wait", gnt_id, 32'd3);
    run_to(5);
    check_eq("t5_id", gnt_id, 32'd1);
    check_eq("t5_pend5", pend, 32'h0);
    run_to(11);
    drain_check("t5_drain");

    // random single requester after reset: always fixed latency
    for (int k = 0; k < 4; k++) begin
      do_reset();
      r = $urandom_range(0, N - 1);
      req = 4'b0001 << r;
      push_gnt(3, 4'b0001 << r);
      tick();
      req = '0;
      check_eq("rnd_id", gnt_id, 32'(r));
      run_to(7);
      drain_check("rnd_drain");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
